// File: rtl/dt_skel.sv
// rtl/dt_skel.sv - medial-axis extractor: scans the 128x128 distance map and writes the packed skeleton
module dt_skel (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        skl_wr,
  output logic [9:0]  skl_addr,
  output logic [15:0] skl_do,
  output logic [13:0] pix_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
  state_t state;

  // stage 1: read data arriving; stage 2: window settled around pixel (r-1,c-1)
  logic        rd_v1;
  logic [13:0] rd_a1;
  logic        px_v;
  logic [13:0] px_a;

  logic [7:0]  lb0 [128];
  logic [7:0]  lb1 [128];
  logic [7:0]  win [3][3];
  logic [15:0] wbuf;
  logic [2:0]  fl_cnt;

  logic [6:0]  px_r;
  logic [6:0]  px_c;
  logic [6:0]  px_rm1;
  logic [2:0]  px_w;
  logic        mark;
  logic        wr_now;
  logic [15:0] wr_word;
  logic [4:0]  wr_ones;

  always_comb begin
    px_r   = px_a[13:7];
    px_c   = px_a[6:0];
    px_rm1 = px_r - 7'd1;
    px_w   = (px_c == 7'd127) ? 3'd7 : (px_c[6:4] - 3'd1);
    mark   = px_v && (px_r >= 7'd2) && (px_c >= 7'd2) && (win[1][1] != 8'd0);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (win[i][j] > win[1][1]) mark = 1'b0;
      end
    end
    // a word closes once its last center column is known; column 127 is border and is appended as 0
    wr_now  = px_v && (px_r != 7'd0) &&
              ((px_c == 7'd127) || ((px_c != 7'd0) && (px_c[3:0] == 4'd0)));
    wr_word = (px_c == 7'd127) ? {wbuf[13:0], mark, 1'b0} : {wbuf[14:0], mark};
    wr_ones = '0;
    for (int k = 0; k < 16; k++) wr_ones = wr_ones + {4'd0, wr_word[k]};
  end

  // line buffers hold rows r-2 and r-1; the window shifts in one column per arriving pixel
  always_ff @(posedge clk) begin
    if (rd_v1) begin
      lb1[rd_a1[6:0]] <= res_di;
      lb0[rd_a1[6:0]] <= lb1[rd_a1[6:0]];
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb0[rd_a1[6:0]];
      win[1][2] <= lb1[rd_a1[6:0]];
      win[2][2] <= res_di;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_rd   <= 1'b0;
      res_addr <= '0;
      skl_wr   <= 1'b0;
      skl_addr <= '0;
      skl_do   <= '0;
      pix_cnt  <= '0;
      rd_v1    <= 1'b0;
      rd_a1    <= '0;
      px_v     <= 1'b0;
      px_a     <= '0;
      wbuf     <= '0;
      fl_cnt   <= '0;
    end else begin
      done   <= 1'b0;
      skl_wr <= 1'b0;
      rd_v1  <= res_rd;
      rd_a1  <= res_addr;
      px_v   <= rd_v1;
      px_a   <= rd_a1;
      if (px_v) wbuf <= {wbuf[14:0], mark};
      if (wr_now) begin
        skl_wr   <= 1'b1;
        skl_addr <= {px_rm1, px_w};
        skl_do   <= wr_word;
        pix_cnt  <= pix_cnt + {9'd0, wr_ones};
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            busy     <= 1'b1;
            res_rd   <= 1'b1;
            res_addr <= '0;
            pix_cnt  <= '0;
            fl_cnt   <= '0;
          end
        end
        SCAN: begin
          if (res_addr == 14'h3fff) begin
            res_rd   <= 1'b0;
            res_addr <= '0;
            state    <= FLUSH;
          end else begin
            res_addr <= res_addr + 14'd1;
          end
        end
        FLUSH: begin
          // row 127 is all border; emit it only after the pipeline has drained so addresses stay ascending
          if (!rd_v1 && !px_v) begin
            skl_wr   <= 1'b1;
            skl_addr <= {7'd127, fl_cnt};
            skl_do   <= '0;
            fl_cnt   <= fl_cnt + 3'd1;
            if (fl_cnt == 3'd7) state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_skel.sv
// tb/tb_dt_skel.sv - randomized and directed bench for dt_skel against a raster-scan reference model
module tb_dt_skel;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        skl_wr;
  logic [9:0]  skl_addr;
  logic [15:0] skl_do;
  logic [13:0] pix_cnt;

  always #5 clk = ~clk;

  dt_skel dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .skl_wr   (skl_wr),
    .skl_addr (skl_addr),
    .skl_do   (skl_do),
    .pix_cnt  (pix_cnt)
  );

  logic [7:0]  mem [16384];
  logic [7:0]  rd_pend = 8'd0;
  logic [15:0] exp_word [1024];
  int          exp_pix;
  logic [9:0]  got_addr [$];
  logic [15:0] got_word [$];
  int cyc = 0, rd_cnt = 0, rd_bad = 0, done_cnt = 0;
  int start_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // result RAM: data for a read seen in cycle t is presented during cycle t+1
  always @(negedge clk) begin
    res_di = rd_pend;
    if (res_rd) begin
      rd_pend = mem[res_addr];
      if (res_addr != rd_cnt[13:0]) rd_bad++;
      rd_cnt++;
    end
    if (skl_wr) begin
      got_addr.push_back(skl_addr);
      got_word.push_back(skl_do);
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic build_model();
    int d;
    bit m;
    exp_pix = 0;
    for (int w = 0; w < 1024; w++) exp_word[w] = 16'h0000;
    for (int r = 1; r <= 126; r++) begin
      for (int c = 1; c <= 126; c++) begin
        d = mem[r*128 + c];
        m = (d > 0);
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (mem[(r+dr)*128 + c + dc] > d) m = 1'b0;
        if (m) begin
          exp_word[r*8 + c/16][15 - c%16] = 1'b1;
          exp_pix++;
        end
      end
    end
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_word.delete();
    rd_cnt = 0;
    rd_bad = 0;
    done_cnt = 0;
    last_wr_cyc = 0;
    done_cyc = 0;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 16384; i++) mem[i] = (mode == 1) ? 8'($urandom_range(0, 3)) : 8'd0;
  endtask

  task automatic run_scan(input string name, input int restart_at);
    int n;
    int bad;
    build_model();
    clear_log();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; start_cyc = cyc;
    chk({name, "_busy_rise"}, busy, 1);
    chk({name, "_first_rd"}, res_rd, 1);
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
      start = (n == restart_at);
    end
    start = 1'b0;
    chk({name, "_done_seen"}, done, 1);
    chk({name, "_busy_fall"}, busy, 0);
    repeat (4) @(negedge clk);
    chk({name, "_done_once"}, done_cnt, 1);
    chk({name, "_reads"}, rd_cnt, 16384);
    chk({name, "_rd_order"}, rd_bad, 0);
    chk({name, "_writes"}, got_addr.size(), 1024);
    chk({name, "_done_after_wr"}, done_cyc, last_wr_cyc + 1);
    chk({name, "_latency_ok"}, (last_wr_cyc - start_cyc) <= 16400, 1);
    bad = 0;
    for (int i = 0; i < got_addr.size(); i++) if (got_addr[i] != 10'(i)) bad++;
    chk({name, "_addr_order"}, bad, 0);
    for (int i = 0; i < got_word.size() && i < 1024; i++)
      if (got_word[i] !== exp_word[i]) chk($sformatf("%s_word%0d", name, i), got_word[i], exp_word[i]);
    chk({name, "_words_match"}, bad_words(), 0);
    chk({name, "_pix_cnt"}, pix_cnt, exp_pix);
  endtask

  function automatic int bad_words();
    int b = 0;
    for (int i = 0; i < got_word.size() && i < 1024; i++) if (got_word[i] !== exp_word[i]) b++;
    return b;
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    res_di = 8'd0;
    fill(0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res_rd", res_rd, 0);
    chk("rst_skl_wr", skl_wr, 0);
    chk("rst_res_addr", res_addr, 0);
    chk("rst_skl_addr", skl_addr, 0);
    chk("rst_skl_do", skl_do, 0);
    chk("rst_pix_cnt", pix_cnt, 0);

    run_scan("zero", 0);
    chk("zero_pix_const", pix_cnt, 0);

    fill(0);
    for (int r = 10; r <= 14; r++)
      for (int c = 20; c <= 24; c++)
        mem[r*128 + c] = (r == 12 && c == 22) ? 8'd3 :
                         (r == 10 || r == 14 || c == 20 || c == 24) ? 8'd1 : 8'd2;
    mem[5*128 + 30] = 8'd1;
    mem[5*128 + 31] = 8'd1;
    mem[0*128 + 5] = 8'd7;
    mem[127*128 + 127] = 8'd7;
    mem[40*128 + 0] = 8'd7;
    run_scan("directed", 0);
    if (got_word.size() == 1024) begin
      chk("chamfer_w97", got_word[97], 16'h0200);
      chk("plateau_w41", got_word[41], 16'h0003);
      chk("border_w0", got_word[0], 16'h0000);
      chk("border_w1023", got_word[1023], 16'h0000);
    end
    chk("directed_pix_const", pix_cnt, 3);

    fill(1);
    run_scan("random", 0);

    fill(1);
    clear_log();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4999) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_res_rd", res_rd, 0);
    chk("abort_skl_wr", skl_wr, 0);
    chk("abort_pix_cnt", pix_cnt, 0);
    reset = 1'b0;
    clear_log();
    repeat (100) @(negedge clk);
    chk("abort_no_reads", rd_cnt, 0);
    chk("abort_no_writes", got_addr.size(), 0);

    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_in_reset_busy", busy, 0);
    chk("start_in_reset_rd", res_rd, 0);

    fill(0);
    mem[64*128 + 64] = 8'd1;
    run_scan("single", 3000);
    if (got_word.size() == 1024) chk("single_w516", got_word[516], 16'h8000);
    chk("single_pix_const", pix_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
